decode_rgf_wr_arb: RTL and testbench

- Arbitrates the single register-file write port between the in-order writeback pipeline and a long-latency unit (mul/div, future FPU) that returns results out of band.
- Buffers long-latency results in a small FIFO and drains them into idle writeback slots.
- Keeps a pending-write scoreboard so decode can interlock on registers whose result has not yet been written.
- Asserts a pipeline stall request when a buffered result has starved too long.

---
 rtl/decode_rgf_wr_arb.sv | 213 +++++++++++++++++++++
 tb/tb_decode_rgf_wr_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_rgf_wr_arb.sv
// -----------------------------------------------------------------------------
// decode_rgf_wr_arb
//
// Shares the single register-file write port between the in-order writeback
// stage and a long-latency unit that returns results out of band.
//
// Long-latency results are held in a small FIFO. They drain into any
// writeback slot that is not carrying a real write.
//
// A pending-write scoreboard tracks every long-latency destination from issue
// until its result is written. Decode uses it to interlock.
//
// If a buffered result is blocked for too long, stall_req asks the front-end
// to inject bubbles until the FIFO drains.
//
// Optional build macro: RGF_ARB_PERF_EN adds the saturating counters
// perf_ll_wr and perf_stall.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wb_we/wb_wa/wb_wd         writeback write request (always has priority)
//   ll_issue_vld/ll_issue_wa  long-latency op issued; marks rd as pending
//   ll_vld/ll_rdy/ll_wa/ll_wd long-latency result handshake
//   rgf_we/rgf_wa/rgf_wd      register-file write port (combinational)
//   dec_rs1/dec_rs2/dec_rd    decode operands checked against the scoreboard
//   pend_hit                  decode must bubble
//   stall_req                 starvation stall request (registered)
//   perf_ll_wr, perf_stall    (RGF_ARB_PERF_EN only) performance counters
// -----------------------------------------------------------------------------
module decode_rgf_wr_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8,
  parameter int REGS_PTR_W = 5,
  parameter int REG_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [REGS_PTR_W-1:0] wb_wa,
  input  logic [REG_SIZE-1:0]   wb_wd,
  input  logic                  ll_issue_vld,
  input  logic [REGS_PTR_W-1:0] ll_issue_wa,
  input  logic                  ll_vld,
  output logic                  ll_rdy,
  input  logic [REGS_PTR_W-1:0] ll_wa,
  input  logic [REG_SIZE-1:0]   ll_wd,
  output logic                  rgf_we,
  output logic [REGS_PTR_W-1:0] rgf_wa,
  output logic [REG_SIZE-1:0]   rgf_wd,
  input  logic [REGS_PTR_W-1:0] dec_rs1,
  input  logic [REGS_PTR_W-1:0] dec_rs2,
  input  logic [REGS_PTR_W-1:0] dec_rd,
  output logic                  pend_hit,
  output logic                  stall_req
`ifdef RGF_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ll_wr,
  output logic [31:0]           perf_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREGS = 1 << REGS_PTR_W;

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [REGS_PTR_W-1:0] fifo_wa [FIFO_DEPTH];
  logic [REG_SIZE-1:0]   fifo_wd [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_next;
  logic                  full, empty, push, pop, slot_busy;
  logic [REGS_PTR_W-1:0] head_wa;
  logic [REG_SIZE-1:0]   head_wd;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_wa   = fifo_wa[rd_ptr];
  assign head_wd   = fifo_wd[rd_ptr];

  // ll_rdy is taken from registered occupancy only. A full FIFO therefore
  // refuses a result even in a cycle where it also pops.
  assign ll_rdy    = ~full;
  assign push      = ll_vld & ll_rdy;

  // A writeback to x0 is not a real write, so the slot counts as free.
  assign slot_busy = wb_we & (wb_wa != '0);
  assign pop       = ~slot_busy & ~empty;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples pre-edge values, whatever order the blocks run in.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  // NOTE: the storage array has no reset. An empty count already marks every
  // entry invalid, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa[wr_ptr] <= ll_wa;
      fifo_wd[wr_ptr] <= ll_wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Write-port mux. A head entry addressed to x0 is discarded with we=0.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    rgf_we = 1'b0;
    rgf_wa = '0;
    rgf_wd = '0;
    if (slot_busy) begin
      rgf_we = 1'b1;
      rgf_wa = wb_wa;
      rgf_wd = wb_wd;
    end else if (!empty) begin
      rgf_we = (head_wa != '0);
      rgf_wa = head_wa;
      rgf_wd = head_wd;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard.
  // The set is applied after the clear, so a same-cycle issue to the register
  // being written leaves the bit pending for the newer op.
  // ---------------------------------------------------------------------------
  logic [NREGS-1:0] pend, pend_next;

  always_comb begin
    pend_next = pend;
    if (pop)          pend_next[head_wa]     = 1'b0;
    if (ll_issue_vld) pend_next[ll_issue_wa] = 1'b1;
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_next;
  end

  assign pend_hit = pend[dec_rs1] | pend[dec_rs2] | pend[dec_rd];

  // ---------------------------------------------------------------------------
  // Starvation detection.
  // A cycle is "blocked" when the head is waiting behind a busy slot.
  // Any cycle that is not blocked either pops or has an empty FIFO, and both
  // of those cases restart the count.
  // ---------------------------------------------------------------------------
  logic       blocked, stall_next;
  logic [7:0] starve_cnt, starve_next;

  assign blocked = ~empty & slot_busy;

  always_comb begin
    starve_next = starve_cnt;
    if (!blocked)       starve_next = '0;
    else if (!stall_req) starve_next = starve_cnt + 8'd1;

    // The stall is raised on the edge where the count reaches STARVE_MAX.
    // It is dropped on the edge where the FIFO goes empty.
    stall_next = stall_req;
    if (count_next == '0)
      stall_next = 1'b0;
    else if (blocked && (({1'b0, starve_cnt} + 9'd1) >= 9'(STARVE_MAX)))
      stall_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      stall_req  <= stall_next;
    end
  end

`ifdef RGF_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ll_wr <= '0;
      perf_stall <= '0;
    end else begin
      if (pop && (head_wa != '0) && (perf_ll_wr != '1)) perf_ll_wr <= perf_ll_wr + 32'd1;
      if (stall_req && (perf_stall != '1))              perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_rgf_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_decode_rgf_wr_arb
//
// Directed bench for decode_rgf_wr_arb with a scoreboard-checked write port.
//
// Each stimulus cycle pushes the register-file write it expects into exp_q.
// A monitor compares every rgf_we=1 cycle against the head of that queue.
// Control outputs (ll_rdy, pend_hit, stall_req) are checked inline with
// check().
// -----------------------------------------------------------------------------
module tb_decode_rgf_wr_arb;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, ll_issue_vld, ll_vld;
  logic [4:0]  wb_wa, ll_issue_wa, ll_wa, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] wb_wd, ll_wd;
  logic        ll_rdy, rgf_we, pend_hit, stall_req;
  logic [4:0]  rgf_wa;
  logic [31:0] rgf_wd;
`ifdef RGF_ARB_PERF_EN
  logic [31:0] perf_ll_wr, perf_stall;
`endif

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];

  decode_rgf_wr_arb dut (
    .clk          (clk),
    .rst          (rst),
    .wb_we        (wb_we),
    .wb_wa        (wb_wa),
    .wb_wd        (wb_wd),
    .ll_issue_vld (ll_issue_vld),
    .ll_issue_wa  (ll_issue_wa),
    .ll_vld       (ll_vld),
    .ll_rdy       (ll_rdy),
    .ll_wa        (ll_wa),
    .ll_wd        (ll_wd),
    .rgf_we       (rgf_we),
    .rgf_wa       (rgf_wa),
    .rgf_wd       (rgf_wd),
    .dec_rs1      (dec_rs1),
    .dec_rs2      (dec_rs2),
    .dec_rd       (dec_rd),
    .pend_hit     (pend_hit),
    .stall_req    (stall_req)
`ifdef RGF_ARB_PERF_EN
    ,
    .perf_ll_wr   (perf_ll_wr),
    .perf_stall   (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input logic [4:0] wa, input logic [31:0] wd);
    wr_t e;
    e.wa = wa;
    e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic clr_inputs();
    wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
    ll_issue_vld = 1'b0; ll_issue_wa = '0;
    ll_vld = 1'b0; ll_wa = '0; ll_wd = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
  endtask

  // Advance to just after the next active edge; new stimulus goes here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write-port monitor: every real write must match the next expected one.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && rgf_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rgf_unexpected: got wa=%0d wd=0x%0h expected no write", rgf_wa, rgf_wd);
      end else begin
        e = exp_q.pop_front();
        if (rgf_wa !== e.wa || rgf_wd !== e.wd) begin
          n_fail++;
          $display("FAIL rgf_write: got wa=%0d wd=0x%0h expected wa=%0d wd=0x%0h",
                   rgf_wa, rgf_wd, e.wa, e.wd);
        end
      end
    end
  end

  initial begin
    clr_inputs();
    rst = 1'b1;

    // ---------------- reset state ----------------
    @(negedge clk);
    dec_rs1 = 5'd5;
    #1;
    check("rst_ll_rdy",    32'(ll_rdy),    32'd1);
    check("rst_stall_req", 32'(stall_req), 32'd0);
    check("rst_rgf_we",    32'(rgf_we),    32'd0);
    check("rst_pend_hit",  32'(pend_hit),  32'd0);
    #1 rst = 1'b0;
    clr_inputs();
    step();

    // ---------------- idle slot drain ----------------
    ll_issue_vld = 1'b1; ll_issue_wa = 5'd5;
    dec_rs1 = 5'd5;
    @(negedge clk);
    check("drain_pend_pre_issue", 32'(pend_hit), 32'd0);
    step();
    ll_issue_vld = 1'b0;
    ll_vld = 1'b1; ll_wa = 5'd5; ll_wd = 32'h1234;
    exp_wr(5'd5, 32'h1234);
    @(negedge clk);
    check("drain_pend_before", 32'(pend_hit), 32'd1);
    check("drain_ll_rdy",      32'(ll_rdy),   32'd1);
    check("drain_no_write_yet", 32'(rgf_we),  32'd0);
    step();
    ll_vld = 1'b0;
    @(negedge clk);
    check("drain_we",          32'(rgf_we),   32'd1);
    check("drain_pend_during", 32'(pend_hit), 32'd1);
    step();
    @(negedge clk);
    check("drain_pend_after",  32'(pend_hit), 32'd0);
    step();

    // ---------------- writeback priority + starvation ----------------
    for (int c = 1; c <= 13; c++) begin
      clr_inputs();
      if (c <= 11) begin
        wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h300 + 32'(c);
        exp_wr(5'd3, 32'h300 + 32'(c));
      end
      if (c == 1) begin ll_vld = 1'b1; ll_wa = 5'd10; ll_wd = 32'hA0A0; end
      if (c == 2) begin ll_vld = 1'b1; ll_wa = 5'd11; ll_wd = 32'hB0B0; end
      if (c == 12) exp_wr(5'd10, 32'hA0A0);
      if (c == 13) exp_wr(5'd11, 32'hB0B0);
      @(negedge clk);
      if (c == 9)  check("prio_stall_not_yet", 32'(stall_req), 32'd0);
      if (c >= 10) check($sformatf("prio_stall_c%0d", c), 32'(stall_req), 32'd1);
      step();
    end
    clr_inputs();
    @(negedge clk);
    check("prio_stall_cleared", 32'(stall_req), 32'd0);
    step();

    // ---------------- full FIFO ----------------
    for (int c = 1; c <= 11; c++) begin
      clr_inputs();
      if (c <= 5) begin
        wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h600 + 32'(c);
        exp_wr(5'd3, 32'h600 + 32'(c));
      end
      if (c <= 4) begin ll_vld = 1'b1; ll_wa = 5'(11 + c); ll_wd = 32'hC000 + 32'(c); end
      if (c >= 5 && c <= 7) begin ll_vld = 1'b1; ll_wa = 5'd16; ll_wd = 32'hC005; end
      if (c >= 6 && c <= 9) exp_wr(5'(6 + c), 32'hC000 + 32'(c - 5));
      if (c == 10) exp_wr(5'd16, 32'hC005);
      @(negedge clk);
      if (c == 4) check("full_rdy_3_entries", 32'(ll_rdy), 32'd1);
      if (c == 5) check("full_rdy_low",       32'(ll_rdy), 32'd0);
      if (c == 6) check("full_rdy_low_pop",   32'(ll_rdy), 32'd0);
      if (c == 7) check("full_rdy_back",      32'(ll_rdy), 32'd1);
      step();
    end

    // ---------------- x0 handling ----------------
    clr_inputs();
    wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h400;
    ll_vld = 1'b1; ll_wa = 5'd7; ll_wd = 32'hAA;
    exp_wr(5'd3, 32'h400);
    step();
    wb_wa = 5'd0; wb_wd = 32'hDEAD;
    ll_wa = 5'd0; ll_wd = 32'h55;
    exp_wr(5'd7, 32'hAA);
    @(negedge clk);
    check("x0_head_written", 32'(rgf_wa), 32'd7);
    step();
    clr_inputs();
    @(negedge clk);
    check("x0_ll_r0_dropped", 32'(rgf_we), 32'd0);
    step();
    wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'hBEEF;
    @(negedge clk);
    check("x0_wb_r0_dropped", 32'(rgf_we), 32'd0);
    check("x0_fifo_empty",    32'(ll_rdy), 32'd1);
    step();

    // ---------------- scoreboard race ----------------
    clr_inputs();
    wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h500;
    ll_issue_vld = 1'b1; ll_issue_wa = 5'd9;
    ll_vld = 1'b1; ll_wa = 5'd9; ll_wd = 32'h99;
    exp_wr(5'd3, 32'h500);
    step();
    clr_inputs();
    ll_issue_vld = 1'b1; ll_issue_wa = 5'd9;
    dec_rd = 5'd9;
    exp_wr(5'd9, 32'h99);
    @(negedge clk);
    check("race_pend_before", 32'(pend_hit), 32'd1);
    step();
    clr_inputs();
    dec_rd = 5'd9;
    ll_vld = 1'b1; ll_wa = 5'd9; ll_wd = 32'h999;
    exp_wr(5'd9, 32'h999);
    @(negedge clk);
    check("race_pend_kept", 32'(pend_hit), 32'd1);
    step();
    clr_inputs();
    dec_rd = 5'd9;
    @(negedge clk);
    check("race_pend_until_write", 32'(pend_hit), 32'd1);
    step();
    clr_inputs();
    dec_rs2 = 5'd9;
    @(negedge clk);
    check("race_pend_cleared", 32'(pend_hit), 32'd0);
    step();

    // ---------------- async reset mid-drain ----------------
    for (int c = 1; c <= 10; c++) begin
      clr_inputs();
      wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h700 + 32'(c);
      exp_wr(5'd3, 32'h700 + 32'(c));
      if (c <= 3) begin
        ll_issue_vld = 1'b1; ll_issue_wa = 5'(19 + c);
        ll_vld = 1'b1; ll_wa = 5'(19 + c); ll_wd = 32'hE000 + 32'(c);
      end
      @(negedge clk);
      if (c == 10) check("rst_mid_stall_set", 32'(stall_req), 32'd1);
      step();
    end
    clr_inputs();
    dec_rs1 = 5'd20; dec_rs2 = 5'd21; dec_rd = 5'd22;
    exp_wr(5'd20, 32'hE001);
    @(negedge clk);
    check("rst_mid_pend_before", 32'(pend_hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_stall",  32'(stall_req), 32'd0);
    check("rst_mid_rgf_we", 32'(rgf_we),    32'd0);
    check("rst_mid_pend",   32'(pend_hit),  32'd0);
    check("rst_mid_ll_rdy", 32'(ll_rdy),    32'd1);
    #1 rst = 1'b0;
    step();
    @(negedge clk);
    check("rst_post_ll_rdy", 32'(ll_rdy),   32'd1);
    check("rst_post_rgf_we", 32'(rgf_we),   32'd0);
    check("rst_post_pend",   32'(pend_hit), 32'd0);
    step();

    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
